// File: rtl/frame_tx_stream.sv
// Ethernet II frame transmitter with a streamed payload.
// Serialises preamble/SFD, header, payload, zero pad and FCS onto a byte bus, one byte per clk.
// The FSM state names the segment of the byte that the next clock edge will emit.
module frame_tx_stream #(
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter int unsigned IFG_CYCLES  = 12,
  parameter int unsigned PREAMBLE_EN = 1,
  parameter int unsigned FCS_EN      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [47:0] dest_addr,
  input  logic [47:0] src_addr,
  input  logic [15:0] eth_type,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  input  logic        pl_last,
  output logic        pl_ready,
  output logic [7:0]  tx_out,
  output logic        tx_en,
  output logic        tx_done,
  output logic        tx_err,
  output logic        busy
);

  localparam logic [10:0] MinPl  = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MaxPl  = 11'(MAX_PAYLOAD);
  localparam logic [15:0] IfgLen = 16'(IFG_CYCLES);

  typedef enum logic [3:0] {
    StIdle, StPre, StSfd, StDst, StSrc, StTyp, StPay, StPad, StFcs, StIfg
  } state_e;

  localparam state_e AfterData = (FCS_EN != 0) ? StFcs : StIfg;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [10:0] pay_cnt_q;
  logic        ovf_q;
  logic [31:0] crc_q;
  logic [47:0] dst_q;
  logic [47:0] src_q;
  logic [15:0] typ_q;

  logic [7:0]  data_byte;
  logic [31:0] crc_upd;
  logic [10:0] pay_inc;
  logic [31:0] fcs_word;
  logic [7:0]  fcs_byte;

  // Reflected CRC-32 (poly 0x04C11DB7), one byte, LSB first.
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Byte idx of a MAC address, most significant byte first.
  function automatic logic [7:0] addr_byte(input logic [47:0] a, input logic [2:0] idx);
    return a[8*(5-int'(idx)) +: 8];
  endfunction

  // Byte that the next edge emits for CRC-covered states, plus the CRC after it.
  always_comb begin
    data_byte = 8'h00;
    case (state_q)
      StDst:   data_byte = addr_byte(dst_q, cnt_q[2:0]);
      StSrc:   data_byte = addr_byte(src_q, cnt_q[2:0]);
      StTyp:   data_byte = cnt_q[0] ? typ_q[7:0] : typ_q[15:8];
      StPay:   data_byte = pl_data;
      default: data_byte = 8'h00;
    endcase
    crc_upd  = crc_next(crc_q, data_byte);
    pay_inc  = (pay_cnt_q == 11'h7FF) ? pay_cnt_q : pay_cnt_q + 11'd1;
    fcs_word = ~crc_q;
    fcs_byte = fcs_word[8*int'(cnt_q[1:0]) +: 8];
  end

  // Handshake and status decoded from the state register.
  always_comb begin
    pl_ready = (state_q == StPay) && !ovf_q;
    busy     = (state_q != StIdle);
  end

  // Frame sequencer with registered byte-bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pay_cnt_q <= '0;
      ovf_q     <= 1'b0;
      crc_q     <= '0;
      dst_q     <= '0;
      src_q     <= '0;
      typ_q     <= '0;
      tx_out    <= 8'h00;
      tx_en     <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state_q)
        StIdle: begin
          tx_out <= 8'h00;
          tx_en  <= 1'b0;
          if (start) begin
            dst_q     <= dest_addr;
            src_q     <= src_addr;
            typ_q     <= eth_type;
            pay_cnt_q <= '0;
            ovf_q     <= 1'b0;
            tx_en     <= 1'b1;
            cnt_q     <= 16'd1;
            // First byte goes out straight from the inputs being latched.
            if (PREAMBLE_EN != 0) begin
              tx_out  <= 8'h55;
              crc_q   <= 32'hFFFFFFFF;
              state_q <= StPre;
            end else begin
              tx_out  <= dest_addr[47:40];
              crc_q   <= crc_next(32'hFFFFFFFF, dest_addr[47:40]);
              state_q <= StDst;
            end
          end
        end
        StPre: begin
          tx_out <= 8'h55;
          tx_en  <= 1'b1;
          if (cnt_q == 16'd6) begin
            state_q <= StSfd;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StSfd: begin
          tx_out  <= 8'hD5;
          tx_en   <= 1'b1;
          state_q <= StDst;
          cnt_q   <= '0;
        end
        StDst, StSrc, StTyp: begin
          tx_out <= data_byte;
          tx_en  <= 1'b1;
          crc_q  <= crc_upd;
          if (state_q == StTyp && cnt_q == 16'd1) begin
            state_q <= StPay;
            cnt_q   <= '0;
          end else if (state_q != StTyp && cnt_q == 16'd5) begin
            state_q <= (state_q == StDst) ? StSrc : StTyp;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StPay: begin
          if (!pl_valid || ovf_q) begin
            // Underrun or oversize: drop the frame, the abort cycle is the first gap cycle.
            tx_out  <= 8'h00;
            tx_en   <= 1'b0;
            tx_err  <= 1'b1;
            ovf_q   <= 1'b0;
            state_q <= StIfg;
            cnt_q   <= 16'd1;
          end else begin
            tx_out    <= data_byte;
            tx_en     <= 1'b1;
            crc_q     <= crc_upd;
            pay_cnt_q <= pay_inc;
            cnt_q     <= '0;
            if (pl_last) begin
              state_q <= (pay_inc >= MinPl) ? AfterData : StPad;
            end else if (pay_inc >= MaxPl) begin
              ovf_q <= 1'b1;
            end
          end
        end
        StPad: begin
          tx_out    <= 8'h00;
          tx_en     <= 1'b1;
          crc_q     <= crc_upd;
          pay_cnt_q <= pay_inc;
          cnt_q     <= '0;
          if (pay_inc >= MinPl) state_q <= AfterData;
        end
        StFcs: begin
          tx_out <= fcs_byte;
          tx_en  <= 1'b1;
          if (cnt_q == 16'd3) begin
            state_q <= StIfg;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StIfg: begin
          tx_out  <= 8'h00;
          tx_en   <= 1'b0;
          // cnt_q is 0 only on the normal-completion path, never after an abort.
          tx_done <= (cnt_q == 16'd0);
          if (cnt_q >= IfgLen) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_out  <= 8'h00;
          tx_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx_stream.sv
// Directed self-checking bench for frame_tx_stream (default build plus a MAX_PAYLOAD=64 build).
module tb_frame_tx_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        m_start = 1'b0;
  logic [47:0] dest_addr = '0;
  logic [47:0] src_addr = '0;
  logic [15:0] eth_type = '0;
  logic [7:0]  pl_data = '0;
  logic        pl_valid = 1'b0;
  logic        pl_last = 1'b0;

  logic        pl_ready, tx_en, tx_done, tx_err, busy;
  logic [7:0]  tx_out;
  logic        m_pl_ready, m_tx_en, m_tx_done, m_tx_err, m_busy;
  logic [7:0]  m_tx_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] pay [0:127];
  logic [7:0] exp_q[$];

  // Monitor records for the default build.
  logic [7:0] cap[$];
  int done_q[$], err_q[$], rise_q[$], fall_q[$], bfree_q[$];
  int n_rdy = 0, n_bad = 0;
  logic en_prev = 1'b0, busy_prev = 1'b0;
  // Monitor records for the MAX_PAYLOAD=64 build.
  logic [7:0] m_cap[$];
  int m_done_q[$], m_err_q[$], m_fall_q[$];
  int m_n_rdy = 0, m_n_bad = 0;
  logic m_en_prev = 1'b0;

  frame_tx_stream dut (
    .clk(clk), .rst(rst), .start(start), .dest_addr(dest_addr), .src_addr(src_addr),
    .eth_type(eth_type), .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last),
    .pl_ready(pl_ready), .tx_out(tx_out), .tx_en(tx_en), .tx_done(tx_done),
    .tx_err(tx_err), .busy(busy)
  );

  frame_tx_stream #(.MAX_PAYLOAD(64)) dut_max (
    .clk(clk), .rst(rst), .start(m_start), .dest_addr(dest_addr), .src_addr(src_addr),
    .eth_type(eth_type), .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last),
    .pl_ready(m_pl_ready), .tx_out(m_tx_out), .tx_en(m_tx_en), .tx_done(m_tx_done),
    .tx_err(m_tx_err), .busy(m_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_en) cap.push_back(tx_out);
    if (!tx_en && tx_out != 8'h00) n_bad++;
    if (tx_done) done_q.push_back(cyc);
    if (tx_err) err_q.push_back(cyc);
    if (tx_en && !en_prev) rise_q.push_back(cyc);
    if (!tx_en && en_prev) fall_q.push_back(cyc);
    if (!busy && busy_prev) bfree_q.push_back(cyc);
    if (pl_ready) n_rdy++;
    en_prev = tx_en;
    busy_prev = busy;
  end

  always @(negedge clk) begin
    if (m_tx_en) m_cap.push_back(m_tx_out);
    if (!m_tx_en && m_tx_out != 8'h00) m_n_bad++;
    if (m_tx_done) m_done_q.push_back(cyc);
    if (m_tx_err) m_err_q.push_back(cyc);
    if (!m_tx_en && m_en_prev) m_fall_q.push_back(cyc);
    if (m_pl_ready) m_n_rdy++;
    m_en_prev = m_tx_en;
  end

  task automatic check_val(input string tag, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Golden CRC-32, bit-serial over the data bits LSB first.
  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  // Appends one expected frame (payload from pay[]) to exp_q.
  task automatic build_exp(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                           input int n, input bit abort);
    logic [31:0] c;
    logic [7:0]  b;
    logic [31:0] f;
    int tot;
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 6; i++) begin
      b = d[47-8*i -: 8]; exp_q.push_back(b); c = crc_model(c, b);
    end
    for (int i = 0; i < 6; i++) begin
      b = s[47-8*i -: 8]; exp_q.push_back(b); c = crc_model(c, b);
    end
    b = t[15:8]; exp_q.push_back(b); c = crc_model(c, b);
    b = t[7:0];  exp_q.push_back(b); c = crc_model(c, b);
    tot = abort ? n : ((n < 46) ? 46 : n);
    for (int i = 0; i < tot; i++) begin
      b = (i < n) ? pay[i] : 8'h00;
      exp_q.push_back(b);
      c = crc_model(c, b);
    end
    if (!abort) begin
      f = ~c;
      exp_q.push_back(f[7:0]);
      exp_q.push_back(f[15:8]);
      exp_q.push_back(f[23:16]);
      exp_q.push_back(f[31:24]);
    end
  endtask

  task automatic compare_cap(input string name, input bit on_max, input int base);
    int got_len;
    logic [7:0] v;
    got_len = (on_max ? m_cap.size() : cap.size()) - base;
    check_val({name, "_len"}, longint'(got_len), longint'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_len; i++) begin
      v = on_max ? m_cap[base+i] : cap[base+i];
      check_val($sformatf("%s_byte%0d", name, i), longint'(v), longint'(exp_q[i]));
    end
  endtask

  task automatic start_frame(input bit on_max);
    @(posedge clk); #1;
    if (on_max) m_start = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_start = 1'b0;
  endtask

  // Streams pay[0..n-1]; gives up after idle_lim consecutive cycles without acceptance.
  task automatic feed(input int n, input bit with_last, input bit on_max, input int idle_lim,
                      output int acc);
    int idle;
    logic rdy;
    acc = 0;
    idle = 0;
    pl_valid = 1'b1;
    pl_data = pay[0];
    pl_last = with_last && (n == 1);
    while (acc < n && idle < idle_lim) begin
      @(negedge clk);
      rdy = on_max ? m_pl_ready : pl_ready;
      @(posedge clk); #1;
      if (rdy) begin
        acc++;
        idle = 0;
        if (acc < n) begin
          pl_data = pay[acc];
          pl_last = with_last && (acc == n - 1);
        end
      end else begin
        idle++;
      end
    end
    pl_valid = 1'b0;
    pl_last = 1'b0;
    pl_data = 8'h00;
  endtask

  task automatic wait_idle(input string name, input bit on_max, input int lim);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((on_max ? m_busy : busy) && k < lim);
    if (on_max ? m_busy : busy) check_val({name, "_idle_timeout"}, 64'd1, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int base, nd, ne, nr, nf, nrdy, acc, nb;

    // Reset state
    #12;
    check_val("rst_tx_out", longint'(tx_out), 0);
    check_val("rst_tx_en", longint'(tx_en), 0);
    check_val("rst_tx_done", longint'(tx_done), 0);
    check_val("rst_tx_err", longint'(tx_err), 0);
    check_val("rst_busy", longint'(busy), 0);
    check_val("rst_pl_ready", longint'(pl_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Test 1: 4-byte payload, padded to 46
    base = cap.size(); nd = done_q.size(); ne = err_q.size(); nb = bfree_q.size();
    dest_addr = 48'h123456789ABC; src_addr = 48'hABCDEF123456; eth_type = 16'h0800;
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
    exp_q.delete();
    build_exp(dest_addr, src_addr, eth_type, 4, 1'b0);
    check_val("t1_exp_len", longint'(exp_q.size()), 72);
    start_frame(1'b0);
    feed(4, 1'b1, 1'b0, 60, acc);
    wait_idle("t1", 1'b0, 200);
    compare_cap("t1", 1'b0, base);
    check_val("t1_done_cnt", longint'(done_q.size() - nd), 1);
    check_val("t1_err_cnt", longint'(err_q.size() - ne), 0);
    if (done_q.size() > nd && fall_q.size() > 0 && bfree_q.size() > nb) begin
      check_val("t1_done_at_fall", longint'(done_q[nd]), longint'(fall_q[$]));
      check_val("t1_ifg_len", longint'(bfree_q[nb] - done_q[nd]), 12);
    end

    // Test 2: 60-byte gapless payload, no pad; a mid-frame start pulse is ignored
    base = cap.size(); nd = done_q.size(); nr = rise_q.size(); nrdy = n_rdy;
    dest_addr = 48'h0200_0000_0001; src_addr = 48'h0200_0000_0002; eth_type = 16'h88B5;
    for (int i = 0; i < 60; i++) pay[i] = 8'(i * 7 + 3);
    exp_q.delete();
    build_exp(dest_addr, src_addr, eth_type, 60, 1'b0);
    start_frame(1'b0);
    fork
      feed(60, 1'b1, 1'b0, 60, acc);
      begin
        repeat (30) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    wait_idle("t2", 1'b0, 200);
    compare_cap("t2", 1'b0, base);
    check_val("t2_rdy_cycles", longint'(n_rdy - nrdy), 60);
    check_val("t2_done_cnt", longint'(done_q.size() - nd), 1);
    check_val("t2_frames", longint'(rise_q.size() - nr), 1);

    // Test 3: underrun after 10 bytes
    base = cap.size(); nd = done_q.size(); ne = err_q.size(); nf = fall_q.size();
    nb = bfree_q.size();
    dest_addr = 48'hFFFF_FFFF_FFFF; src_addr = 48'h0011_2233_4455; eth_type = 16'h0806;
    for (int i = 0; i < 10; i++) pay[i] = 8'h30 + 8'(i);
    exp_q.delete();
    build_exp(dest_addr, src_addr, eth_type, 10, 1'b1);
    start_frame(1'b0);
    feed(10, 1'b0, 1'b0, 60, acc);
    wait_idle("t3", 1'b0, 200);
    compare_cap("t3", 1'b0, base);
    check_val("t3_err_cnt", longint'(err_q.size() - ne), 1);
    check_val("t3_done_cnt", longint'(done_q.size() - nd), 0);
    if (err_q.size() > ne && fall_q.size() > nf && bfree_q.size() > nb) begin
      check_val("t3_err_at_fall", longint'(err_q[ne]), longint'(fall_q[nf]));
      check_val("t3_ifg_len", longint'(bfree_q[nb] - err_q[ne]), 12);
    end

    // Test 4: MAX_PAYLOAD=64 build, 70 bytes offered without pl_last
    base = m_cap.size(); nrdy = m_n_rdy;
    dest_addr = 48'h0A0B_0C0D_0E0F; src_addr = 48'h1020_3040_5060; eth_type = 16'h86DD;
    for (int i = 0; i < 70; i++) pay[i] = 8'hA0 + 8'(i);
    exp_q.delete();
    build_exp(dest_addr, src_addr, eth_type, 64, 1'b1);
    start_frame(1'b1);
    feed(70, 1'b0, 1'b1, 40, acc);
    wait_idle("t4", 1'b1, 200);
    check_val("t4_accepted", longint'(acc), 64);
    compare_cap("t4", 1'b1, base);
    check_val("t4_rdy_cycles", longint'(m_n_rdy - nrdy), 64);
    check_val("t4_err_cnt", longint'(m_err_q.size()), 1);
    check_val("t4_done_cnt", longint'(m_done_q.size()), 0);
    if (m_err_q.size() > 0 && m_fall_q.size() > 0)
      check_val("t4_err_at_fall", longint'(m_err_q[0]), longint'(m_fall_q[$]));

    // Test 5: start held high; header changed mid-frame goes only into the next frame
    base = cap.size(); nd = done_q.size(); nr = rise_q.size();
    dest_addr = 48'h1111_2222_3333; src_addr = 48'h4444_5555_6666; eth_type = 16'h0801;
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
    exp_q.delete();
    build_exp(dest_addr, src_addr, eth_type, 4, 1'b0);
    @(posedge clk); #1 start = 1'b1;
    feed(4, 1'b1, 1'b0, 60, acc);
    dest_addr = 48'h7777_8888_9999; src_addr = 48'hAAAA_BBBB_CCCC; eth_type = 16'h0802;
    pay[0] = 8'hF1; pay[1] = 8'hF2; pay[2] = 8'hF3; pay[3] = 8'hF4;
    build_exp(dest_addr, src_addr, eth_type, 4, 1'b0);
    feed(4, 1'b1, 1'b0, 200, acc);
    start = 1'b0;
    wait_idle("t5", 1'b0, 200);
    compare_cap("t5", 1'b0, base);
    check_val("t5_done_cnt", longint'(done_q.size() - nd), 2);
    check_val("t5_frames", longint'(rise_q.size() - nr), 2);
    if (rise_q.size() > nr + 1 && done_q.size() > nd)
      check_val("t5_restart_gap", longint'(rise_q[nr+1] - done_q[nd]), 13);

    // Test 6: asynchronous reset during DST bytes, then a clean frame
    dest_addr = 48'h5555_6666_7777; src_addr = 48'h8888_9999_AAAA; eth_type = 16'h0800;
    start_frame(1'b0);
    repeat (9) @(posedge clk);
    #2 check_val("t6_in_frame", longint'(tx_en), 1);
    #1 rst = 1'b1;
    #1;
    check_val("t6_tx_en", longint'(tx_en), 0);
    check_val("t6_tx_out", longint'(tx_out), 0);
    check_val("t6_busy", longint'(busy), 0);
    check_val("t6_tx_err", longint'(tx_err), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    base = cap.size(); nd = done_q.size();
    dest_addr = 48'hDEAD_BEEF_0001; src_addr = 48'hCAFE_F00D_0002; eth_type = 16'h0800;
    for (int i = 0; i < 20; i++) pay[i] = 8'h5A ^ 8'(i);
    exp_q.delete();
    build_exp(dest_addr, src_addr, eth_type, 20, 1'b0);
    start_frame(1'b0);
    feed(20, 1'b1, 1'b0, 60, acc);
    wait_idle("t6", 1'b0, 200);
    compare_cap("t6", 1'b0, base);
    check_val("t6_done_cnt", longint'(done_q.size() - nd), 1);

    check_val("idle_bus_zero", longint'(n_bad), 0);
    check_val("idle_bus_zero_max", longint'(m_n_bad), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
